// File: rtl/uart_boot_loader_if.sv
// Instruction-memory write port used by uart_boot_loader.
// Handshake: a write is accepted on a rising clk edge where mem_req and mem_ready
// are both high; mem_addr/mem_wdata are held stable while mem_req is high and not yet accepted.
interface uart_boot_loader_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (output mem_req, output mem_addr, output mem_wdata, input mem_ready);
  modport slave  (input mem_req, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: parses A5/LEN/data[/CSUM] frames, writes LE words to imem, releases the core.
// Optional checksum byte is enabled by defining UART_BOOT_LOADER_CSUM_EN.
module uart_boot_loader #(
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int                MAX_WORDS      = 4096,
  parameter int                TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                rx_valid,
  input  logic                rx_break,
  input  logic [7:0]          rx_data,
  output logic                rx_en,
  uart_boot_loader_if.master  mem,
  output logic                cpu_rst_n,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  // Where a frame goes once its last word is written (or LEN is zero).
`ifdef UART_BOOT_LOADER_CSUM_EN
  localparam state_t S_FINAL = S_CSUM;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state, nxt;
  logic [TW-1:0]     idle_cnt;
  logic [7:0]        len_lo;
  logic [15:0]       words_left;
  logic [1:0]        byte_cnt;
  logic [31:0]       wdata;
  logic [ADDR_W-1:0] addr;
  logic              mem_req_q;
`ifdef UART_BOOT_LOADER_CSUM_EN
  logic [7:0]        csum;
`endif

  logic        counting, in_frame, timeout, abort, sync, accept;
  logic [15:0] len_in;

  assign counting = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA) || (state == S_CSUM);
  assign in_frame = counting || (state == S_WRITE);
  assign timeout  = counting && (idle_cnt == TW'(TIMEOUT_CYCLES));
  assign abort    = in_frame && ((rx_valid && rx_break) || timeout || (rx_valid && state == S_WRITE));
  assign sync     = rx_valid && !rx_break && (rx_data == 8'hA5);
  assign accept   = mem_req_q && mem.mem_ready;
  assign len_in   = {rx_data, len_lo};

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = S_ERR;
    end else begin
      case (state)
        S_IDLE, S_ERR: if (sync) nxt = S_LEN0;
        S_LEN0:        if (rx_valid) nxt = S_LEN1;
        S_LEN1: if (rx_valid) begin
          if ({16'd0, len_in} > 32'(MAX_WORDS)) nxt = S_ERR;
          else if (len_in == 16'd0)             nxt = S_FINAL;
          else                                  nxt = S_DATA;
        end
        S_DATA:  if (rx_valid && byte_cnt == 2'd3) nxt = S_WRITE;
        S_WRITE: if (accept) nxt = (words_left == 16'd1) ? S_FINAL : S_DATA;
`ifdef UART_BOOT_LOADER_CSUM_EN
        S_CSUM:  if (rx_valid) nxt = (rx_data == csum) ? S_DONE : S_ERR;
`endif
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next state so they change together with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      rx_en      <= 1'b0;
      mem_req_q  <= 1'b0;
      cpu_rst_n  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      idle_cnt   <= '0;
      len_lo     <= '0;
      words_left <= '0;
      byte_cnt   <= '0;
      wdata      <= '0;
      addr       <= BASE_ADDR;
`ifdef UART_BOOT_LOADER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      state     <= nxt;
      rx_en     <= (nxt != S_DONE);
      mem_req_q <= (nxt == S_WRITE);
      cpu_rst_n <= (nxt == S_DONE);
      done      <= (nxt == S_DONE);
      err       <= (nxt == S_ERR);
      busy      <= nxt inside {S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM};
      idle_cnt  <= (rx_valid || !counting) ? '0 : idle_cnt + TW'(1);

      if (sync && (state == S_IDLE || state == S_ERR)) begin
        addr     <= BASE_ADDR;
        byte_cnt <= '0;
`ifdef UART_BOOT_LOADER_CSUM_EN
        csum     <= '0;
`endif
      end
      if (state == S_LEN0 && rx_valid) len_lo     <= rx_data;
      if (state == S_LEN1 && rx_valid) words_left <= len_in;
      // Bytes arrive LSB first, so shifting in from the top yields a little-endian word.
      if (state == S_DATA && rx_valid && !abort) begin
        wdata    <= {rx_data, wdata[31:8]};
        byte_cnt <= byte_cnt + 2'd1;
`ifdef UART_BOOT_LOADER_CSUM_EN
        csum     <= csum ^ rx_data;
`endif
      end
      if (state == S_WRITE && accept && !abort) begin
        addr       <= addr + ADDR_W'(4);
        words_left <= words_left - 16'd1;
      end
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_addr  = {addr[ADDR_W-1:2], 2'b00};
  assign mem.mem_wdata = wdata;
  assign dbg_state     = state;

endmodule
